// File: rtl/seq_pattern_tx_if.sv
// Launch handshake and serial output bundle for seq_pattern_tx.
// master = controller side, slave = transmitter side.
interface seq_pattern_tx_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] rep_cnt;
    logic             x;
    logic             frame;
    logic             busy;
    logic             done;

    modport master (output start, rep_cnt, input x, frame, busy, done);
    modport slave  (input start, rep_cnt, output x, frame, busy, done);
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends PATTERN MSB first, repeated rep_cnt times.
// Define SEQ_PATTERN_TX_GAP_EN to insert one idle cycle between repetitions.
module seq_pattern_tx #(
    parameter int             PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
    parameter int             CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    seq_pattern_tx_if.slave   bus
);
    localparam int BIT_W = $clog2(PAT_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);

`ifdef SEQ_PATTERN_TX_GAP_EN
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

    state_t           state;
    logic [PAT_W-1:0] shreg;
    logic [BIT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] remain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            remain    <= '0;
            bus.x     <= 1'b0;
            bus.frame <= 1'b0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    bus.x     <= 1'b0;
                    bus.frame <= 1'b0;
                    bus.busy  <= 1'b0;
                    if (bus.start) begin
                        // A zero count still sends one repetition.
                        remain    <= (bus.rep_cnt == '0) ? CNT_W'(1) : bus.rep_cnt;
                        shreg     <= PATTERN;
                        bus.x     <= PATTERN[PAT_W-1];
                        bus.frame <= 1'b1;
                        bus.busy  <= 1'b1;
                        bit_cnt   <= '0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (bit_cnt == LAST_BIT) begin
                        remain  <= remain - CNT_W'(1);
                        bit_cnt <= '0;
                        if (remain == CNT_W'(1)) begin
                            bus.x     <= 1'b0;
                            bus.frame <= 1'b0;
                            bus.busy  <= 1'b0;
                            bus.done  <= 1'b1;
                            state     <= IDLE;
                        end else begin
`ifdef SEQ_PATTERN_TX_GAP_EN
                            bus.x     <= 1'b0;
                            bus.frame <= 1'b0;
                            state     <= GAP;
`else
                            shreg     <= PATTERN;
                            bus.x     <= PATTERN[PAT_W-1];
`endif
                        end
                    end else begin
                        // x shows shreg MSB; the next bit sits just below it.
                        shreg   <= shreg << 1;
                        bus.x   <= shreg[PAT_W-2];
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end
`ifdef SEQ_PATTERN_TX_GAP_EN
                GAP: begin
                    shreg     <= PATTERN;
                    bus.x     <= PATTERN[PAT_W-1];
                    bus.frame <= 1'b1;
                    bit_cnt   <= '0;
                    state     <= SEND;
                end
`endif
                default: begin
                    bus.x     <= 1'b0;
                    bus.frame <= 1'b0;
                    bus.busy  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx with the default 1101 pattern.
// Outputs are sampled 1 time unit after each rising edge.
module tb_seq_pattern_tx;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [3:0] pat = 4'b1101;

    seq_pattern_tx_if #(.CNT_W(CNT_W)) bus ();

    seq_pattern_tx #(
        .PAT_W   (4),
        .PATTERN (4'b1101),
        .CNT_W   (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {x, frame, busy, done}
    function automatic logic [3:0] outs();
        return {bus.x, bus.frame, bus.busy, bus.done};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int n);
        bus.rep_cnt = CNT_W'(n);
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
    endtask

    // Checks every cycle of an n-repetition burst starting at the current cycle,
    // then the done cycle; returns one cycle after done.
    task automatic expect_burst(input string tag, input int n, input int poke_cyc, input int chg_cyc);
        int cyc = 0;
        for (int r = 0; r < n; r++) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("%s_r%0d_b%0d", tag, r, i), outs(), {pat[3-i], 1'b1, 1'b1, 1'b0});
                if (cyc == poke_cyc) bus.start = 1'b1;
                if (cyc == chg_cyc) bus.rep_cnt = 8'd7;
                tick();
                if (cyc == poke_cyc) bus.start = 1'b0;
                cyc++;
            end
`ifdef SEQ_PATTERN_TX_GAP_EN
            if (r < n - 1) begin
                check($sformatf("%s_gap%0d", tag, r), outs(), 4'b0010);
                tick();
                cyc++;
            end
`endif
        end
        check($sformatf("%s_done", tag), outs(), 4'b0001);
        tick();
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.rep_cnt = '0;
        rst         = 1'b1;
        repeat (2) tick();
        check("reset_outs", outs(), 4'b0000);
        rst = 1'b0;
        tick();
        check("idle_after_reset", outs(), 4'b0000);
        tick();
        check("idle_hold", outs(), 4'b0000);

        launch(1);
        expect_burst("single", 1, -1, -1);
        check("post_single", outs(), 4'b0000);

        launch(3);
        expect_burst("triple", 3, -1, -1);
        check("post_triple", outs(), 4'b0000);

        launch(0);
        expect_burst("zero_cnt", 1, -1, -1);
        check("post_zero", outs(), 4'b0000);

        launch(1);
        expect_burst("busy_start", 1, 1, -1);
        check("busy_start_not_queued", outs(), 4'b0000);
        tick();
        check("busy_start_idle", outs(), 4'b0000);

        launch(2);
        expect_burst("cnt_change", 2, -1, 2);
        check("post_cnt_change", outs(), 4'b0000);
        bus.rep_cnt = '0;

        // start held high across the whole burst and its done cycle
        bus.rep_cnt = 8'd1;
        bus.start   = 1'b1;
        tick();
        expect_burst("hold1", 1, -1, -1);
        bus.start = 1'b0;
        expect_burst("hold2", 1, -1, -1);
        check("post_hold", outs(), 4'b0000);

        launch(5);
        repeat (7) tick();
        check("mid_busy", {31'd0, bus.busy}, 32'd1);
        #2 rst = 1'b1;
        #1 check("mid_rst_async", outs(), 4'b0000);
        tick();
        check("mid_rst_no_done", outs(), 4'b0000);
        rst = 1'b0;
        tick();
        check("mid_rst_idle", outs(), 4'b0000);
        tick();
        check("mid_rst_idle2", outs(), 4'b0000);
        launch(5);
        expect_burst("after_rst", 5, -1, -1);
        check("post_after_rst", outs(), 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter that drives a single-bit serial line with a fixed bit pattern, by default `1101`, MSB first. It repeats the pattern a programmable number of times. It is the stimulus end of the serial sequence-detection path: its `x` output feeds the `x` input of the sequence detector. A start/busy/done handshake lets a controller launch bursts.

## Interface
Parameters:
- `PAT_W`, default 4 — pattern length in bits (≥2).
- `PATTERN`, default `4'b1101` — pattern transmitted MSB first; width `PAT_W`.
- `CNT_W`, default 8 — width of the repeat-count input.

Ports:
- `clk`  in  1  — single clock; all state changes on its rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `start`  in  1  — launch request; sampled only in IDLE.
- `rep_cnt`  in  `CNT_W`  — number of pattern repetitions; latched at launch.
- `x`  out  1  — serial data line, registered.
- `frame`  out  1  — high while `x` carries a pattern bit, registered.
- `busy`  out  1  — high from the first bit through the last bit of the burst.
- `done`  out  1  — one-cycle pulse after the last bit of the burst.

## Operation
- **States:** IDLE, SEND, GAP. GAP exists only when the gap feature is enabled (see Configuration).
- **Reset:** `rst` high forces IDLE asynchronously. All outputs go to 0 (`x`, `frame`, `busy`, `done`), and the shift register, bit counter and repeat counter clear.
- **IDLE:**
  - `x`=0, `frame`=0, `busy`=0.
  - `start`=1 latches `rep_cnt` into the remaining-count register. `rep_cnt`=0 is treated as 1.
  - The same edge loads the shift register with `PATTERN`, drives `x` with `PATTERN[PAT_W-1]`, clears the bit counter, and enters SEND.
- **SEND:**
  - Each cycle presents one bit on `x` with `frame`=1, shifting left.
  - The bit counter counts 0..`PAT_W-1`.
  - On the last bit of a repetition, the remaining count decrements. Then:
    - remaining >0 and gap disabled: reload `PATTERN` and continue in SEND, back-to-back.
    - remaining >0 and gap enabled: go to GAP.
    - remaining =0: go to IDLE and assert `done` for the next cycle.
- **GAP:** one cycle with `x`=0, `frame`=0, `busy`=1. Then reload `PATTERN` and return to SEND.
- **start handling:**
  - `start` while `busy` is ignored. It is not queued.
  - `start` during the `done` cycle is accepted, because the FSM is already in IDLE.
- **rep_cnt handling:** changes to `rep_cnt` after launch have no effect.
- **Arithmetic:**
  - The remaining count is `CNT_W` bits and decrements only at repetition boundaries, so it never wraps.
  - The bit counter is `$clog2(PAT_W)` bits and resets at each repetition.

## Timing
- `start` sampled high in IDLE at edge T:
  - first bit on `x` during cycle T+1;
  - `busy`=1 and `frame`=1 from T+1.
- Burst length:
  - gap disabled: N·`PAT_W` bit cycles;
  - gap enabled: N·`PAT_W` + (N−1) cycles.
- `done` is high for exactly one cycle, the cycle immediately after the last bit, with `busy`=0 and `x`=0.
- Launch latency from `start` to first bit is 1 cycle.
- Minimum spacing between bursts: last bit, then the `done` cycle with `start` accepted, then the first bit of the next burst.
- Reset mid-burst: outputs go to 0 immediately on `rst` assertion, with no `done` pulse. After deassertion the block waits in IDLE for `start`.

## Configuration
- **`SEQ_PATTERN_TX_GAP_EN` defined:** one idle cycle (`x`=0, `frame`=0) between consecutive repetitions. A downstream overlapping detector then sees isolated patterns. For the default `1101`, this gives N detections for N repetitions, with no spurious overlap hits.
- **Undefined:**
  - Repetitions are back-to-back and GAP is not compiled in.
  - The stream for N=2 is `11011101`.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → `x`, `frame`, `busy`, `done` all 0 before the next edge; the FSM stays IDLE after release.
- **Single burst:** `rep_cnt`=1, `start` at edge T → `x`=1,1,0,1 in cycles T+1..T+4, `frame`=1 for those cycles, `done`=1 only at T+5.
- **Triple burst:** `rep_cnt`=3:
  - gap undefined → 12 bits `110111011101`, `done` at T+13;
  - `SEQ_PATTERN_TX_GAP_EN` defined → `1101 0 1101 0 1101` over 14 cycles, `frame`=0 in the two gap cycles, `done` at T+15.
- **Zero count:** `rep_cnt`=0 → behaves identically to `rep_cnt`=1 (4 bits, `done` at T+5).
- **Handshake:**
  - `start` pulsed at T+2 during a `rep_cnt`=1 burst → ignored, exactly 4 bits sent;
  - `start` held high through the `done` cycle → the second burst's first bit appears the cycle after `done`;
  - `rep_cnt` changed mid-burst → no effect.
- **Reset mid-burst:** `rep_cnt`=5, assert `rst` at bit 7 → outputs 0 immediately, no `done`; the next `start` produces a full 5-repetition burst from bit 0.
